// File: rtl/riscv_pkg.sv
// Shared RISC-V slice definitions: access size codes, LSU state encoding and
// small helpers for alignment checking and store-lane replication.
package riscv_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_WAIT   = 2'd2,
        LSU_RESP   = 2'd3
    } lsu_state_e;

    // Size code 3 is handled as a word access everywhere.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SIZE_WORD : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr[0];
            default:   bad = (addr != 2'd0);
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            SIZE_BYTE: rep = {4{data[7:0]}};
            SIZE_HALF: rep = {2{data[15:0]}};
            default:   rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/riscv_lsu_extract.sv
// Load data alignment: picks the addressed byte/half out of the memory word
// and sign- or zero-extends it; words pass through untouched.
module riscv_lsu_extract
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        unsigned_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by extension
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data   = 32'h0000_0000;
        case (addr)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        case (size)
            SIZE_BYTE: begin
                if (unsigned_ext) data = {24'h00_0000, byte_s};
                else              data = {{24{byte_s[7]}}, byte_s};
            end
            SIZE_HALF: begin
                if (unsigned_ext) data = {16'h0000, half_s};
                else              data = {{16{half_s[15]}}, half_s};
            end
            default: data = word;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: single-outstanding valid/ready front end driving the
// riscv_memory data port, with misalignment faults and load extension.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_load_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [4:0]  req_rd_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic [4:0]  resp_rd_o,
    output logic        resp_fault_o,
    output logic [31:0] daddr_o,
    output logic [31:0] dwdata_o,
    output logic [1:0]  dsize_o,
    output logic        drd_o,
    output logic        dwr_o,
    input  logic [31:0] drdata_i
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

    lsu_state_e  state_r, next_state_s;
    logic        load_r, unsigned_r;
    logic [1:0]  size_r, lane_r, cnt_r, dsize_r;
    logic [4:0]  rd_r, resp_rd_r;
    logic        req_ready_r, resp_valid_r, resp_fault_r, drd_r, dwr_r;
    logic [31:0] resp_rdata_r, daddr_r, dwdata_r;
    logic        accept_s, misaligned_s, wait_done_s;
    logic [1:0]  req_size_s;
    logic [31:0] ext_s;

    assign req_size_s   = norm_size(req_size_i);
    assign accept_s     = req_valid_i && (state_r == LSU_IDLE);
    assign misaligned_s = is_misaligned(req_size_s, req_addr_i[1:0]);
    assign wait_done_s  = (cnt_r == LAT_LAST);

    riscv_lsu_extract u_extract (
        .word         (drdata_i),
        .addr         (lane_r),
        .size         (size_r),
        .unsigned_ext (unsigned_r),
        .data         (ext_s)
    );

    // FSM state register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_r <= LSU_IDLE;
        else          state_r <= next_state_s;
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            LSU_IDLE: begin
                if (accept_s && misaligned_s) next_state_s = LSU_RESP;
                else if (accept_s)            next_state_s = LSU_ACCESS;
                else                          next_state_s = LSU_IDLE;
            end
            LSU_ACCESS: begin
                if (load_r) next_state_s = LSU_WAIT;
                else        next_state_s = LSU_RESP;
            end
            LSU_WAIT: begin
                if (wait_done_s) next_state_s = LSU_RESP;
                else             next_state_s = LSU_WAIT;
            end
            LSU_RESP: begin
                if (resp_ready_i) next_state_s = LSU_IDLE;
                else              next_state_s = LSU_RESP;
            end
            default: next_state_s = LSU_IDLE;
        endcase
    end

    // Request capture, latency counter and registered port drivers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            load_r       <= 1'b0;
            unsigned_r   <= 1'b0;
            size_r       <= 2'd0;
            lane_r       <= 2'd0;
            rd_r         <= 5'd0;
            cnt_r        <= 2'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_fault_r <= 1'b0;
            resp_rdata_r <= 32'h0;
            resp_rd_r    <= 5'd0;
            daddr_r      <= 32'h0;
            dwdata_r     <= 32'h0;
            dsize_r      <= 2'd0;
            drd_r        <= 1'b0;
            dwr_r        <= 1'b0;
        end else begin
            req_ready_r <= (next_state_s == LSU_IDLE);
            drd_r       <= 1'b0;
            dwr_r       <= 1'b0;
            case (state_r)
                LSU_IDLE: begin
                    if (accept_s) begin
                        load_r     <= req_load_i;
                        unsigned_r <= req_unsigned_i;
                        size_r     <= req_size_s;
                        lane_r     <= req_addr_i[1:0];
                        rd_r       <= req_rd_i;
                        cnt_r      <= 2'd0;
                        if (misaligned_s) begin
                            // Faults skip the memory cycle entirely
                            resp_valid_r <= 1'b1;
                            resp_fault_r <= 1'b1;
                            resp_rdata_r <= 32'h0;
                            resp_rd_r    <= req_load_i ? req_rd_i : 5'd0;
                        end else begin
                            daddr_r  <= req_addr_i;
                            dsize_r  <= req_size_s;
                            dwdata_r <= req_load_i ? 32'h0 : replicate(req_size_s, req_wdata_i);
                            drd_r    <= req_load_i;
                            dwr_r    <= !req_load_i;
                        end
                    end
                end
                LSU_ACCESS: begin
                    if (!load_r) begin
                        resp_valid_r <= 1'b1;
                        resp_rdata_r <= 32'h0;
                        resp_rd_r    <= 5'd0;
                    end
                end
                LSU_WAIT: begin
                    if (wait_done_s) begin
                        resp_valid_r <= 1'b1;
                        resp_rdata_r <= ext_s;
                        resp_rd_r    <= rd_r;
                    end else begin
                        cnt_r <= cnt_r + 2'd1;
                    end
                end
                LSU_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_r <= 1'b0;
                        resp_fault_r <= 1'b0;
                        resp_rdata_r <= 32'h0;
                        resp_rd_r    <= 5'd0;
                        daddr_r      <= 32'h0;
                        dwdata_r     <= 32'h0;
                        dsize_r      <= 2'd0;
                    end
                end
                default: cnt_r <= 2'd0;
            endcase
        end
    end

    assign req_ready_o  = req_ready_r;
    assign resp_valid_o = resp_valid_r;
    assign resp_rdata_o = resp_rdata_r;
    assign resp_rd_o    = resp_rd_r;
    assign resp_fault_o = resp_fault_r;
    assign daddr_o      = daddr_r;
    assign dwdata_o     = dwdata_r;
    assign dsize_o      = dsize_r;
    assign drd_o        = drd_r;
    assign dwr_o        = dwr_r;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: a vector table of loads/stores/faults against a
// small byte-lane memory model, plus backpressure and reset-in-WAIT sequences.
module tb_riscv_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with RD_LATENCY = 1
    logic        rst_n, req_valid, req_ready, req_load, req_unsigned;
    logic [31:0] req_addr, req_wdata, resp_rdata, daddr, dwdata, drdata;
    logic [1:0]  req_size, dsize;
    logic [4:0]  req_rd, resp_rd;
    logic        resp_valid, resp_ready, resp_fault, drd, dwr;

    // Instance with RD_LATENCY = 3
    logic        rst3_n, req_valid3, req_ready3, req_load3, req_unsigned3;
    logic [31:0] req_addr3, req_wdata3, resp_rdata3, daddr3, dwdata3, drdata3;
    logic [1:0]  req_size3, dsize3;
    logic [4:0]  req_rd3, resp_rd3;
    logic        resp_valid3, resp_ready3, resp_fault3, drd3, dwr3;

    riscv_lsu #(.RD_LATENCY(1)) dut (
        .clk_i(clk), .reset_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_load_i(req_load),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
        .req_unsigned_i(req_unsigned), .req_rd_i(req_rd),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
        .resp_rd_o(resp_rd), .resp_fault_o(resp_fault),
        .daddr_o(daddr), .dwdata_o(dwdata), .dsize_o(dsize), .drd_o(drd), .dwr_o(dwr),
        .drdata_i(drdata)
    );

    riscv_lsu #(.RD_LATENCY(3)) dut3 (
        .clk_i(clk), .reset_i(rst3_n),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3), .req_load_i(req_load3),
        .req_addr_i(req_addr3), .req_wdata_i(req_wdata3), .req_size_i(req_size3),
        .req_unsigned_i(req_unsigned3), .req_rd_i(req_rd3),
        .resp_valid_o(resp_valid3), .resp_ready_i(resp_ready3), .resp_rdata_o(resp_rdata3),
        .resp_rd_o(resp_rd3), .resp_fault_o(resp_fault3),
        .daddr_o(daddr3), .dwdata_o(dwdata3), .dsize_o(dsize3), .drd_o(drd3), .dwr_o(dwr3),
        .drdata_i(drdata3)
    );

    // Memory model: byte-lane writes, read data only valid in the right cycle
    logic [31:0] mem [0:1023];
    logic [31:0] p1, p2, p3;

    function automatic bit lane_en(input logic [1:0] sz, input logic [1:0] a, input int i);
        logic [1:0] li;
        li = i[1:0];
        case (sz)
            2'd0:    return a == li;
            2'd1:    return a[1] == li[1];
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            drdata <= 32'hBAD0_BAD0;
        end else begin
            if (dwr) begin
                for (int i = 0; i < 4; i++)
                    if (lane_en(dsize, daddr[1:0], i)) mem[daddr[11:2]][8*i +: 8] <= dwdata[8*i +: 8];
            end
            drdata <= drd ? mem[daddr[11:2]] : 32'hBAD0_BAD0;
        end
    end

    always @(posedge clk) begin
        p1 <= drd3 ? mem[daddr3[11:2]] : 32'hBAD1_BAD1;
        p2 <= p1;
        p3 <= p2;
    end
    assign drdata3 = p3;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        load;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  rd;
        logic        fault;
        logic [1:0]  dsize;
        logic [31:0] dwdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [15];

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        int strobes;
        int exp_lat;
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        req_valid = 1'b1; req_load = v.load; req_addr = v.addr; req_wdata = v.wdata;
        req_size = v.size; req_unsigned = v.uns; req_rd = v.rd;
        @(negedge clk);
        req_valid = 1'b0;
        check({p, "_drd_t1"}, 32'(drd), 32'(v.load & !v.fault));
        check({p, "_dwr_t1"}, 32'(dwr), 32'(!v.load & !v.fault));
        if (!v.fault) begin
            check({p, "_daddr"}, daddr, v.addr);
            check({p, "_dsize"}, 32'(dsize), 32'(v.dsize));
        end
        if (!v.fault && !v.load) check({p, "_dwdata"}, dwdata, v.dwdata);
        n = 1;
        strobes = int'(drd) + int'(dwr);
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
            strobes += int'(drd) + int'(dwr);
        end
        exp_lat = v.fault ? 1 : (v.load ? 3 : 2);
        check({p, "_latency"}, 32'(n), 32'(exp_lat));
        check({p, "_strobes"}, 32'(strobes), v.fault ? 32'd0 : 32'd1);
        check({p, "_fault"}, 32'(resp_fault), 32'(v.fault));
        check({p, "_rdata"}, resp_rdata, v.rdata);
        if (!v.fault) check({p, "_resp_rd"}, 32'(resp_rd), v.load ? 32'(v.rd) : 32'd0);
        check({p, "_ready_busy"}, 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({p, "_valid_after"}, 32'(resp_valid), 32'd0);
        check({p, "_ready_after"}, 32'(req_ready), 32'd1);
        check({p, "_daddr_idle"}, daddr, 32'h0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; rst3_n = 1'b0;
        req_valid = 1'b0; req_load = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_size = 2'd0; req_unsigned = 1'b0; req_rd = 5'd0; resp_ready = 1'b0;
        req_valid3 = 1'b0; req_load3 = 1'b1; req_addr3 = 32'h0; req_wdata3 = 32'h0;
        req_size3 = 2'd2; req_unsigned3 = 1'b0; req_rd3 = 5'd0; resp_ready3 = 1'b0;

        //            load  addr        wdata         sz    uns   rd     flt   dsz   dwdata        rdata
        vecs[0]  = '{1'b0, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 5'd1,  1'b0, 2'd2, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, 32'h100, 32'h0,        2'd2, 1'b0, 5'd5,  1'b0, 2'd2, 32'h0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h103, 32'h0,        2'd0, 1'b0, 5'd6,  1'b0, 2'd0, 32'h0, 32'hFFFFFFDE};
        vecs[3]  = '{1'b1, 32'h103, 32'h0,        2'd0, 1'b1, 5'd6,  1'b0, 2'd0, 32'h0, 32'h000000DE};
        vecs[4]  = '{1'b1, 32'h102, 32'h0,        2'd1, 1'b0, 5'd7,  1'b0, 2'd1, 32'h0, 32'hFFFFDEAD};
        vecs[5]  = '{1'b1, 32'h100, 32'h0,        2'd1, 1'b1, 5'd8,  1'b0, 2'd1, 32'h0, 32'h0000BEEF};
        vecs[6]  = '{1'b1, 32'h100, 32'h0,        2'd0, 1'b0, 5'd9,  1'b0, 2'd0, 32'h0, 32'hFFFFFFEF};
        vecs[7]  = '{1'b0, 32'h202, 32'hFFFFA5A5, 2'd1, 1'b0, 5'd2,  1'b0, 2'd1, 32'hA5A5A5A5, 32'h0};
        vecs[8]  = '{1'b0, 32'h201, 32'h1234563C, 2'd0, 1'b0, 5'd3,  1'b0, 2'd0, 32'h3C3C3C3C, 32'h0};
        vecs[9]  = '{1'b1, 32'h200, 32'h0,        2'd2, 1'b0, 5'd10, 1'b0, 2'd2, 32'h0, 32'hA5A53C00};
        vecs[10] = '{1'b1, 32'h202, 32'h0,        2'd0, 1'b1, 5'd11, 1'b0, 2'd0, 32'h0, 32'h000000A5};
        vecs[11] = '{1'b1, 32'h102, 32'h0,        2'd2, 1'b0, 5'd12, 1'b1, 2'd0, 32'h0, 32'h0};
        vecs[12] = '{1'b0, 32'h101, 32'h1234,     2'd1, 1'b0, 5'd4,  1'b1, 2'd0, 32'h0, 32'h0};
        vecs[13] = '{1'b1, 32'h100, 32'h0,        2'd3, 1'b0, 5'd13, 1'b0, 2'd2, 32'h0, 32'hDEADBEEF};
        vecs[14] = '{1'b1, 32'h202, 32'h0,        2'd1, 1'b0, 5'd14, 1'b0, 2'd1, 32'h0, 32'hFFFFA5A5};

        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_strobes", 32'({drd, dwr}), 32'd0);
        check("rst_daddr", daddr, 32'h0);
        check("rst_dwdata", dwdata, 32'h0);
        check("rst_dsize", 32'(dsize), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_rd_fault", 32'({resp_rd, resp_fault}), 32'd0);
        check("rst3_req_ready", 32'(req_ready3), 32'd1);
        @(negedge clk);
        rst_n = 1'b1; rst3_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

        // Backpressure: response held for 3 cycles, competing request ignored
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b1; req_addr = 32'h100; req_size = 2'd2;
        req_unsigned = 1'b0; req_rd = 5'd7;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", 32'(n), 32'd3);
        req_valid = 1'b1; req_load = 1'b0; req_addr = 32'h300; req_wdata = 32'h1111_1111;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("bp_valid_c%0d", c), 32'(resp_valid), 32'd1);
            check($sformatf("bp_rdata_c%0d", c), resp_rdata, 32'hDEADBEEF);
            check($sformatf("bp_rd_c%0d", c), 32'(resp_rd), 32'd7);
            check($sformatf("bp_ready_c%0d", c), 32'(req_ready), 32'd0);
            check($sformatf("bp_strobe_c%0d", c), 32'({drd, dwr}), 32'd0);
            if (c == 3) begin
                req_valid = 1'b0;
                resp_ready = 1'b1;
            end
            @(negedge clk);
        end
        resp_ready = 1'b0;
        check("bp_ready_after", 32'(req_ready), 32'd1);
        check("bp_valid_after", 32'(resp_valid), 32'd0);
        check("bp_no_store", 32'({drd, dwr}), 32'd0);

        // Reset during WAIT on the RD_LATENCY = 3 instance
        @(negedge clk);
        req_valid3 = 1'b1; req_addr3 = 32'h100; req_size3 = 2'd2; req_rd3 = 5'd9;
        @(negedge clk);
        req_valid3 = 1'b0;
        check("rw_drd_access", 32'(drd3), 32'd1);
        @(negedge clk);
        #2 rst3_n = 1'b0;
        #1;
        check("rw_async_ready", 32'(req_ready3), 32'd1);
        check("rw_async_valid", 32'(resp_valid3), 32'd0);
        check("rw_async_daddr", daddr3, 32'h0);
        check("rw_async_dsize", 32'(dsize3), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst3_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check($sformatf("rw_quiet_valid_c%0d", c), 32'(resp_valid3), 32'd0);
            check($sformatf("rw_quiet_ready_c%0d", c), 32'(req_ready3), 32'd1);
            @(negedge clk);
        end
        req_valid3 = 1'b1; req_addr3 = 32'h100; req_size3 = 2'd2; req_rd3 = 5'd17;
        @(negedge clk);
        req_valid3 = 1'b0;
        n = 1;
        while (!resp_valid3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rw_new_latency", 32'(n), 32'd5);
        check("rw_new_rdata", resp_rdata3, 32'hDEADBEEF);
        check("rw_new_rd", 32'(resp_rd3), 32'd17);
        resp_ready3 = 1'b1;
        @(negedge clk);
        resp_ready3 = 1'b0;
        check("rw_new_ready_after", 32'(req_ready3), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
